// File: rtl/guarded_mem_array.sv
// guarded_mem_array
//   Memory array whose write port only admits values strictly below BOUND.
//   Each entry has a written flag, cleared by reset. Reads of entries that
//   have not been written return 0, so memory contents never need clearing.
//   There are NUM_RD independent read ports. Each one is registered and has
//   1-cycle latency. A read to an address being written in the same cycle
//   returns the old contents (read-first).
//   A saturating counter tallies rejected writes. A sticky inv_err flag goes
//   high if any read port ever presents a value >= BOUND.
//
//   Optional build macro GUARDED_MEM_CLAMP_EN: an out-of-range write stores
//   BOUND-1 instead of being dropped. wr_ack and wr_rej then pulse together,
//   and the reject counter still increments.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data write request (unsigned data)
//   wr_ack, wr_rej        registered accept / reject pulse, one cycle after the write
//   rd_addr               NUM_RD packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data               NUM_RD packed registered read data, same packing
//   reject_cnt            saturating count of rejected writes
//   inv_err               sticky invariant-violation flag

// Per-port output register for read data.
module guarded_mem_rd_port #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= d;
  end
endmodule

module guarded_mem_array #(
  parameter int          DATA_W = 32,
  parameter int          ADDR_W = 8,
  parameter int unsigned BOUND  = 200,
  parameter int          NUM_RD = 2,
  parameter int          CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_ack,
  output logic                     wr_rej,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]         reject_cnt,
  output logic                     inv_err
);
  localparam int                DEPTH   = 2**ADDR_W;
  localparam logic [DATA_W-1:0] BOUND_V = DATA_W'(BOUND);
  localparam logic [DATA_W-1:0] CLAMP_V = BOUND_V - DATA_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  written;

  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr_a;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_raw;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_q;
  logic [NUM_RD-1:0]             rd_ge;

  logic              in_range;
  logic              wr_store;
  logic [DATA_W-1:0] wr_val;

  assign in_range = (wr_data < BOUND_V);

`ifdef GUARDED_MEM_CLAMP_EN
  // Every write lands. Out-of-range data is pinned to the largest legal value.
  assign wr_store = wr_en;
  assign wr_val   = in_range ? wr_data : CLAMP_V;
`else
  assign wr_store = wr_en & in_range;
  assign wr_val   = wr_data;
`endif

  // Storage has no reset; the written flags mask stale contents.
  // Gating on !rst drops a write that coincides with reset.
  always_ff @(posedge clk) begin
    if (wr_store && !rst) mem[wr_addr] <= wr_val;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      written    <= '0;
      wr_ack     <= 1'b0;
      wr_rej     <= 1'b0;
      reject_cnt <= '0;
      inv_err    <= 1'b0;
    end else begin
      wr_ack <= wr_store;
      wr_rej <= wr_en & ~in_range;
      if (wr_store) written[wr_addr] <= 1'b1;
      if (wr_en && !in_range && (reject_cnt != {CNT_W{1'b1}}))
        reject_cnt <= reject_cnt + CNT_W'(1);
      if (|rd_ge) inv_err <= 1'b1;
    end
  end

  assign rd_addr_a = rd_addr;
  assign rd_data   = rd_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    // Reads sample the array before this edge's write commits, which gives read-first.
    assign rd_raw[i] = written[rd_addr_a[i]] ? mem[rd_addr_a[i]] : '0;
    assign rd_ge[i]  = (rd_q[i] >= BOUND_V);

    guarded_mem_rd_port #(.DATA_W(DATA_W)) u_rd (
      .clk (clk),
      .rst (rst),
      .d   (rd_raw[i]),
      .q   (rd_q[i])
    );

    if (i == 0) begin : g_lt0
      always @* lt_bound_0: assert (rd_q[0] < BOUND_V);
    end else if (i == 1) begin : g_lt1
      always @* lt_bound_1: assert (rd_q[1] < BOUND_V);
    end else if (i == 2) begin : g_lt2
      always @* lt_bound_2: assert (rd_q[2] < BOUND_V);
    end else if (i == 3) begin : g_lt3
      always @* lt_bound_3: assert (rd_q[3] < BOUND_V);
    end
  end
endmodule

// File: tb/tb_guarded_mem_array.sv
module tb_guarded_mem_array;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int BOUND  = 200;
  localparam int NUM_RD = 2;
  localparam int CNT_W  = 4;
  localparam int DEPTH  = 256;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     wr_ack, wr_rej;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [CNT_W-1:0]         reject_cnt;
  logic                     inv_err;

  guarded_mem_array #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BOUND(BOUND), .NUM_RD(NUM_RD), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_rej(wr_rej), .rd_addr(rd_addr), .rd_data(rd_data),
    .reject_cnt(reject_cnt), .inv_err(inv_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: what each address holds, whether it has been written,
  // and how many writes have been rejected in total.
  logic [31:0] m_mem  [DEPTH];
  bit          m_flag [DEPTH];
  int          rej_total;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_flag[i] = 0;
    rej_total = 0;
  endtask

  function automatic logic [31:0] model_read(input int a);
    return m_flag[a] ? m_mem[a] : 32'd0;
  endfunction

  // One clock: apply inputs, predict, clock, then check all outputs.
  task automatic step(input bit we, input int wa, input logic [31:0] wd,
                      input int ra0, input int ra1);
    logic [31:0] e_rd0, e_rd1;
    bit          e_ack, e_rej;
    int          e_cnt;
    wr_en   = we;
    wr_addr = 8'(wa);
    wr_data = wd;
    rd_addr = {8'(ra1), 8'(ra0)};
    e_rd0 = model_read(ra0);
    e_rd1 = model_read(ra1);
    e_ack = 0;
    e_rej = 0;
    if (we) begin
      if (wd < 32'(BOUND)) begin
        m_mem[wa] = wd; m_flag[wa] = 1; e_ack = 1;
      end else begin
        e_rej = 1; rej_total++;
`ifdef GUARDED_MEM_CLAMP_EN
        m_mem[wa] = 32'(BOUND - 1); m_flag[wa] = 1; e_ack = 1;
`endif
      end
    end
    e_cnt = (rej_total > 15) ? 15 : rej_total;
    @(posedge clk); #1;
    chk("wr_ack",     64'(wr_ack),          64'(e_ack));
    chk("wr_rej",     64'(wr_rej),          64'(e_rej));
    chk("rd_data0",   64'(rd_data[31:0]),   64'(e_rd0));
    chk("rd_data1",   64'(rd_data[63:32]),  64'(e_rd1));
    chk("reject_cnt", 64'(reject_cnt),      64'(e_cnt));
    chk("inv_err",    64'(inv_err),         64'd0);
  endtask

  task automatic rand_steps(input int n);
    logic [31:0] wd;
    int r;
    for (int k = 0; k < n; k++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      wd = 32'hFFFF_FFFF;
      else if (r < 4)  wd = $urandom_range(195, 230);
      else             wd = $urandom_range(0, 199);
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 31)), wd,
           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, 64'(wr_ack),     64'd0);
    chk({tag, "_rej"}, 64'(wr_rej),     64'd0);
    chk({tag, "_rd"},  64'(rd_data),    64'd0);
    chk({tag, "_cnt"}, 64'(reject_cnt), 64'd0);
    chk({tag, "_inv"}, 64'(inv_err),    64'd0);
  endtask

  initial begin
    rst = 1'b1; wr_en = 0; wr_addr = 0; wr_data = 0; rd_addr = 0;
    model_reset();
    #12;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Unwritten address reads 0 on both ports.
    step(0, 0, 0, 'h10, 'h10);
    // Accepted write, then read it back.
    step(1, 'h10, 150, 0, 0);
    step(0, 0, 0, 'h10, 'h10);
    // Write at BOUND is rejected; the entry keeps 150 (199 when clamping).
    step(1, 'h10, 200, 0, 0);
    step(0, 0, 0, 'h10, 'h10);
    // Read-during-write returns the old value; the new value appears next cycle.
    step(1, 'h20, 42, 'h20, 'h21);
    step(0, 0, 0, 'h20, 'h20);
    // Largest legal value is accepted.
    step(1, 'h21, 199, 'h21, 'h21);
    step(0, 0, 0, 'h21, 'h20);
    // The counter saturates at 15 under a long run of all-ones writes.
    for (int k = 0; k < 20; k++) step(1, 'h10, 32'hFFFF_FFFF, 'h10, 'h11);
    step(0, 0, 0, 'h10, 'h10);

    rand_steps(400);

    // Reset mid-stream: outputs clear immediately, and the in-flight write is lost.
    step(1, 'h30, 7, 'h10, 'h30);
    step(0, 0, 0, 'h30, 'h21);
    wr_en = 1; wr_addr = 8'h40; wr_data = 9; rd_addr = {8'h30, 8'h30};
    #3 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    step(0, 0, 0, 'h30, 'h40);
    step(1, 'h40, 9, 'h40, 'h30);
    step(0, 0, 0, 'h40, 'h30);

    rand_steps(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
